// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor with a valid/ready handshake.
// Each pipeline stage adds one SEG-bit segment with carry lookahead and
// passes the segment carry, the remaining operand bits and the result bits
// built so far to the next stage, so every stage holds a complete bundle.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be 4..64 and divisible by STAGES");
  end

  logic             advance;

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             cm_q  [STAGES];

  logic             v_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];

  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             c_nxt [STAGES];
  logic             cm_nxt[STAGES];

  // Whole pipe moves as one; a bubble in the last stage never blocks.
  assign advance  = ~v_q[LAST] | out_ready;
  assign in_ready = advance;

  // Stage inputs: stage 0 takes the ports (B inverted and carry forced for
  // subtraction), later stages take the previous stage register.
  always_comb begin
    v_src[0] = in_valid;
    a_src[0] = a;
    b_src[0] = sub ? ~b : b;
    s_src[0] = '0;
    c_src[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
  end

  // Per-stage generate/propagate carry lookahead over this stage's segment.
  always_comb begin
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   cv;
    logic           acc;
    logic           pp;
    g   = '0;
    p   = '0;
    cv  = '0;
    acc = 1'b0;
    pp  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      g     = a_src[k][k*SEG +: SEG] & b_src[k][k*SEG +: SEG];
      p     = a_src[k][k*SEG +: SEG] ^ b_src[k][k*SEG +: SEG];
      cv    = '0;
      cv[0] = c_src[k];
      for (int i = 0; i < SEG; i++) begin
        acc = g[i];
        pp  = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (pp & g[j]);
          pp  = pp & p[j];
        end
        cv[i+1] = acc | (pp & cv[0]);
      end
      s_nxt[k]               = s_src[k];
      s_nxt[k][k*SEG +: SEG] = p ^ cv[SEG-1:0];
      c_nxt[k]               = cv[SEG];
      cm_nxt[k]              = cv[SEG-1];
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        cm_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= v_src[k];
        a_q[k]  <= a_src[k];
        b_q[k]  <= b_src[k];
        s_q[k]  <= s_nxt[k];
        c_q[k]  <= c_nxt[k];
        cm_q[k] <= cm_nxt[k];
      end
    end
  end

  // Flags come from the complete registered sum of the last stage; zero is
  // qualified by valid so an idle or reset pipe reports zero=0.
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = c_q[LAST] ^ cm_q[LAST];
  assign zero      = v_q[LAST] & ~(|s_q[LAST]);
  assign neg       = s_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=16, STAGES=4): directed vectors, stall,
// mid-flight reset and a long random run against an arithmetic model.
module tb_pipe_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int          n_cmp;
  int          n_err;
  int          n_push;
  int          n_pop;
  logic [19:0] exp_q[$];
  logic        hold_pend;
  logic [19:0] hold_val;
  logic [19:0] exp_front;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; carry into MSB from the low 15 bits.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic ci);
    logic [15:0] yy;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    yy   = s ? ~y : y;
    c0   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {16'b0, c0};
    low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'b0, c0};
    return {full[15:0], full[16], low[15] ^ full[16], full[15:0] == 16'h0, full[15]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted bundles queued through the model, results popped in
  // order; a stalled output must be unchanged on the following cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({sum, cout, ovf, zero, neg}), 32'(hold_val));
      end
      hold_pend = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, cin));
        n_push++;
      end
      if (out_valid && out_ready) begin
        chk("out_has_expect", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_front = exp_q.pop_front();
          chk("result", 32'({sum, cout, ovf, zero, neg}), 32'(exp_front));
          n_pop++;
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_val  = {sum, cout, ovf, zero, neg};
      end
    end
  end

  // Single bundle through an empty pipe: absent after 3 edges, present after 4.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic ts, input logic tc, input logic [19:0] exp);
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'({sum, cout, ovf, zero, neg}), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   cyc;
    int   base_push;
    int   base_pop;
    int   seen;
    logic acc;

    n_cmp = 0; n_err = 0; n_push = 0; n_pop = 0; hold_pend = 1'b0;
    hold_val = '0; exp_front = '0;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h1234; b = 16'h0001; sub = 1'b0; cin = 1'b0;

    // Reset: bundle offered during reset must not be captured.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({cout, ovf, zero, neg}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_capture", 32'(seen), 32'd0);

    // Directed vectors: {sum, cout, ovf, zero, neg}
    run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0101});
    run_one("sub_eq",     16'h0005, 16'h0005, 1'b1, 1'b1, {16'h0000, 4'b1010});
    run_one("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, {16'hFFFE, 4'b0001});
    run_one("cin_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, {16'h0000, 4'b1010});
    run_one("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 4'b1100});
    run_one("add_cin",    16'h1234, 16'h4321, 1'b0, 1'b1, {16'h5556, 4'b0000});

    // Eight back-to-back bundles with a three-cycle output stall.
    base_pop = n_pop;
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      a = 16'(idx * 16'h1003);
      b = 16'(16'h0F0F ^ idx);
      sub = idx[0];
      cin = idx[1];
      in_valid = 1'b1;
      #1;
      if (cyc >= 5 && cyc < 8) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    chk("stream_accepted", 32'(idx), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((n_pop - base_pop) < 8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_count", 32'(n_pop - base_pop), 32'd8);
    @(posedge clk); #1;

    // Reset with bundles in flight and one waiting at the output.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'(16'h1111 * (i + 1)); b = 16'h0101; sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data", 32'({sum, cout, ovf, zero, neg}), 32'({16'h1212, 4'b0000}));
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_flags", 32'({cout, ovf, zero, neg}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);

    // Random traffic with random back-pressure.
    base_push = n_push;
    base_pop  = n_pop;
    cyc = 0;
    while ((n_push - base_push) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_accepted", 32'(n_push - base_push), 32'd10000);
    chk("rand_drained", 32'(n_pop - base_pop), 32'd10000);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
